// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and default oversampling.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OS_DEFAULT = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received UART data; push while full is honoured only when a pop frees a slot.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FullLevel);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = level_q;
  assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: dout is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: synchronizer, oversampled bit-timing FSM and output FIFO.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OS    = OS_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  output logic [7:0]               data,
  output logic                     valid,
  input  logic                     ready,
  output logic                     frame_err,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int CW = $clog2(OS);
  localparam logic [CW-1:0] CntHalf = CW'(OS/2 - 1);
  localparam logic [CW-1:0] CntLast = CW'(OS - 1);

  logic          s1_q, s2_q, s2d_q;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          push, pop;
  logic          fifo_full, fifo_empty;

  assign valid     = !fifo_empty;
  assign pop       = valid && ready;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  // cnt wraps naturally modulo OS because OS is a power of two.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2d_q && !s2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntHalf) begin
          if (!s2_q) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          shift_d[idx_q] = s2_q;
          idx_d          = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = IDLE;
          if (!s2_q)                  frame_err_d = 1'b1;
          else if (!fifo_full || pop) push        = 1'b1;
          else                        overrun_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      s2d_q       <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s1_q        <= rx;
      s2_q        <= s1_q;
      s2d_q       <= s2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (shift_q),
    .pop   (pop),
    .dout  (data),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed and randomized frames against a queue-based model of the receiver and its FIFO.
module tb_uart_rx_ctrl;

  localparam int OS          = 8;
  localparam int DEPTH       = 4;
  localparam int LW          = $clog2(DEPTH) + 1;
  localparam int FrameCycles = 10 * OS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          ready = 1'b0;
  logic [7:0]    data;
  logic          valid;
  logic          frame_err;
  logic          overrun;
  logic [LW-1:0] level;

  int testCount = 0;
  int failCount = 0;
  int ferrSeen = 0;
  int ovrSeen = 0;
  int expFerr = 0;
  int expOvr = 0;
  logic [7:0] modelQ[$];

  uart_rx_ctrl #(.OS(OS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Each high cycle of a pulse output counts once, so a stretched pulse shows up as an extra event.
  always @(negedge clk) begin
    if (frame_err) ferrSeen++;
    if (overrun)   ovrSeen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, ".level"}, 32'(level), 32'(modelQ.size()));
    checkOutput({tag, ".valid"}, 32'(valid), 32'(modelQ.size() > 0));
    if (modelQ.size() > 0) checkOutput({tag, ".data"}, 32'(data), 32'(modelQ[0]));
    checkOutput({tag, ".frame_err"}, 32'(ferrSeen), 32'(expFerr));
    checkOutput({tag, ".overrun"}, 32'(ovrSeen), 32'(expOvr));
  endtask

  task automatic popOne(input string tag);
    logic [7:0] tmp;
    checkOutput({tag, ".valid"}, 32'(valid), 32'd1);
    if (modelQ.size() > 0) begin
      checkOutput({tag, ".data"}, 32'(data), 32'(modelQ[0]));
      tmp = modelQ.pop_front();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  // Sends one frame; the value set in iteration c is on the line at the (c+1)th following edge.
  // abortAt >= 0 pulses reset at that point of the frame instead of finishing it.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input bit popAtStop,
                               input bit checkLatency, input int abortAt);
    logic [9:0] frame;
    logic [7:0] tmp;
    bit         popped;
    frame  = {stopBit, b, 1'b0};
    popped = 1'b0;
    for (int c = 0; c < FrameCycles; c++) begin
      if (c == abortAt) begin
        rst_n = 1'b0;
        rx    = 1'b1;
        tick();
        rst_n = 1'b1;
        modelQ.delete();
        return;
      end
      rx = frame[c/OS];
      if (c == FrameCycles - 2) begin
        if (checkLatency) checkOutput("latency.valid_before", 32'(valid), 32'd0);
        if (popAtStop && modelQ.size() > 0) begin
          ready  = 1'b1;
          popped = 1'b1;
          checkOutput("stop_pop.data", 32'(data), 32'(modelQ[0]));
        end
      end
      if (c == FrameCycles - 1) begin
        ready = 1'b0;
        if (checkLatency) checkOutput("latency.valid_after", 32'(valid), 32'd1);
      end
      tick();
    end
    rx = 1'b1;
    if (popped) tmp = modelQ.pop_front();
    if (!stopBit) expFerr++;
    else if (modelQ.size() < DEPTH) modelQ.push_back(b);
    else expOvr++;
  endtask

  initial begin
    logic [7:0] rb;
    logic       rgood;
    int         npop;

    rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset.valid", 32'(valid), 32'd0);
    checkOutput("reset.level", 32'(level), 32'd0);
    checkOutput("reset.data", 32'(data), 32'd0);
    checkOutput("reset.frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset.overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    idle(5);

    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1, -1);
    idle(4);
    checkAgainstModel("a5");
    checkOutput("a5.data_exact", 32'(data), 32'h0000_00A5);
    popOne("a5_pop");

    ready = 1'b1;
    repeat (3) tick();
    ready = 1'b0;
    checkOutput("empty_pop.level", 32'(level), 32'd0);

    rx = 1'b0;
    repeat (2) tick();
    idle(20);
    checkAgainstModel("glitch");

    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, -1);
    idle(4);
    checkAgainstModel("ferr");
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, -1);
    idle(4);
    checkAgainstModel("after_ferr");
    popOne("p55");

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(8'(i), 1'b1, 1'b0, 1'b0, -1);
      idle(3);
      checkAgainstModel("fill");
    end
    applyStimulus(8'h77, 1'b1, 1'b1, 1'b0, -1);
    idle(3);
    checkAgainstModel("full_pop_push");
    repeat (4) popOne("drain");
    checkAgainstModel("drained");

    applyStimulus(8'h99, 1'b1, 1'b0, 1'b0, -1);
    idle(3);
    checkAgainstModel("pre_abort");
    applyStimulus(8'hE7, 1'b1, 1'b0, 1'b0, 4*OS + 3);
    idle(20);
    checkAgainstModel("abort");
    applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0, -1);
    idle(3);
    checkAgainstModel("c3");
    popOne("c3_pop");

    for (int f = 0; f < 12; f++) begin
      rb    = 8'($urandom);
      rgood = ($urandom_range(0, 4) != 0);
      applyStimulus(rb, rgood, 1'b0, 1'b0, -1);
      idle($urandom_range(1, 6));
      checkAgainstModel("rand");
      npop = $urandom_range(0, modelQ.size());
      repeat (npop) popOne("rand_pop");
    end
    checkAgainstModel("final");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter OS, default 8, is the clk cycles per bit; it SHALL be a power of two, 4 or more.
REQ-002 Parameter DEPTH, default 4, is the receive FIFO depth in bytes; it SHALL be a power of two, 2 or more.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-006 data  output  8  byte at the FIFO head; valid only while valid=1.
REQ-007 valid  output  1  FIFO not empty.
REQ-008 ready  input  1  consumer accept; a pop occurs when valid and ready are both 1 on a clk edge.
REQ-009 frame_err  output  1  one-cycle pulse: the stop bit was sampled low.
REQ-010 overrun  output  1  one-cycle pulse: a completed byte was dropped because the FIFO was full.
REQ-011 level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-012 rx SHALL pass through a two-flop synchronizer (s1, s2); all decisions use s2 and the previous value of s2 (s2_d).
REQ-013 The FSM SHALL have four states, IDLE, START, DATA and STOP, plus a bit-timer cnt of $clog2(OS) bits and a bit index idx of 3 bits.
REQ-014 IDLE: when s2_d=1 and s2=0, go to START and clear cnt to 0; otherwise stay.
REQ-015 START: increment cnt; at cnt=OS/2-1, sample s2: 0 goes to DATA with cnt=0 and idx=0; 1 is a false start and returns to IDLE with no output.
REQ-016 DATA: increment cnt modulo OS; at cnt=OS-1, shift s2 into shift-register bit idx (LSB first) and increment idx; after the sample with idx=7, go to STOP with cnt=0.
REQ-017 STOP: at cnt=OS-1, sample s2 and return to IDLE.
  - If s2=1 and the FIFO is not full, or a pop occurs in the same cycle, push the byte.
  - If s2=1, the FIFO is full and no pop occurs, drop the byte and pulse overrun.
  - If s2=0, discard the byte and pulse frame_err; no push.
REQ-018 Each sample point SHALL therefore fall mid-bit: OS/2 cycles after the detected falling edge, then every OS cycles.
REQ-019 Latency: valid SHALL rise on the cycle after the stop-bit sample edge when the FIFO was empty.
REQ-020 FIFO: a write pointer and a read pointer of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - level updates by +1 on push only, -1 on pop only, and 0 on push with pop.
  - Full is level=DEPTH; empty is level=0.
REQ-021 A pop while empty SHALL be ignored; data and valid SHALL stay stable while valid=1 and ready=0.
REQ-022 A falling edge while the FSM is in START, DATA or STOP SHALL be ignored; only IDLE detects start bits.
REQ-023 After a frame error the line may stay low; a new frame SHALL be detected only after s2 returns high and then falls.

Reset
REQ-024 While rst_n=0 at a clk edge:
  - s1, s2 and s2_d load 1.
  - The FSM goes to IDLE; cnt, idx and the shift register load 0.
  - Both pointers and level load 0.
  - valid, frame_err and overrun are 0; data is 0.
REQ-025 Reset mid-frame SHALL abandon the frame without a push or an error pulse; FIFO contents are discarded.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state enum (IDLE, START, DATA, STOP) and the default OS constant, for reuse by a future transmitter.
REQ-027 The FIFO SHALL be a sub-module uart_rx_fifo with ports clk, rst_n, push, din, pop, dout, level, full and empty; the FSM and timing stay in uart_rx_ctrl.

Verification
REQ-028 With OS=8 and the FIFO empty, drive byte 0xA5 at 8 clk/bit -> exactly one push; valid rises, data=0xA5, level=1, no error pulses.
REQ-029 Drive a 2-clk low glitch on rx while IDLE -> false start; FSM back in IDLE; no push; level stays 0.
REQ-030 Drive 0x3C with the stop bit low -> frame_err pulses for 1 cycle; level unchanged; the following 0x55 is received correctly after the line returns high.
REQ-031 With ready=0, send 5 bytes 0x01..0x05 with DEPTH=4 -> level=4, overrun pulses once on byte 0x05; pops return 0x01..0x04 in order.
REQ-032 With FIFO full, assert ready=1 on the stop-sample cycle of byte 0x77 -> push and pop both occur; no overrun; level stays 4; 0x77 becomes the last entry.
REQ-033 Assert rst_n=0 for 1 cycle during DATA bit 3 of a frame -> no push and no error pulse; the next full frame 0xC3 is received correctly.
